// File: rtl/msrv_32_pkg.sv
// msrv_32_pkg: shared encodings for the MSRV32 machine-mode trap sequencer.
package msrv_32_pkg;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_OPERATING,
        ST_TRAP_TAKEN,
        ST_TRAP_RETURN
    } state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_NEXT = 2'b10;
    localparam logic [1:0] PC_TRAP = 2'b11;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
    localparam logic [6:0] FUNCT7_ENV    = 7'b0000000;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
    localparam logic [4:0] RS2_ECALL     = 5'b00000;
    localparam logic [4:0] RS2_EBREAK    = 5'b00001;
    localparam logic [4:0] RS2_MRET      = 5'b00010;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_M_SW_INT         = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER_INT      = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT_INT        = 4'd11;

endpackage

// File: rtl/msrv_32_trap_priority.sv
// msrv_32_trap_priority: picks the winning trap; exceptions outrank interrupts.
module msrv_32_trap_priority
    import msrv_32_pkg::*;
(
    input  logic       illegal,
    input  logic       misaligned_instr,
    input  logic       ecall,
    input  logic       ebreak,
    input  logic       misaligned_load,
    input  logic       misaligned_store,
    input  logic       ext_int,
    input  logic       sw_int,
    input  logic       timer_int,
    output logic       trap_present,
    output logic [3:0] cause,
    output logic       is_interrupt,
    output logic       is_misaligned
);

    logic exception;

    always_comb begin
        exception     = illegal | misaligned_instr | ecall | ebreak | misaligned_load | misaligned_store;
        trap_present  = exception | ext_int | sw_int | timer_int;
        is_interrupt  = !exception & (ext_int | sw_int | timer_int);
        cause         = illegal          ? CAUSE_ILLEGAL_INSTR    :
                        misaligned_instr ? CAUSE_INSTR_MISALIGNED :
                        ecall            ? CAUSE_ECALL_M          :
                        ebreak           ? CAUSE_BREAKPOINT       :
                        misaligned_load  ? CAUSE_LOAD_MISALIGNED  :
                        misaligned_store ? CAUSE_STORE_MISALIGNED :
                        ext_int          ? CAUSE_M_EXT_INT        :
                        sw_int           ? CAUSE_M_SW_INT         :
                        timer_int        ? CAUSE_M_TIMER_INT      : 4'd0;
        // mtval comes from the faulting address only when a misalignment is the winner
        is_misaligned = !illegal & (misaligned_instr |
                        (!ecall & !ebreak & (misaligned_load | misaligned_store)));
    end

endmodule

// File: rtl/msrv_32_trap_controller.sv
// msrv_32_trap_controller: M-mode trap/return FSM driving PC source, flush and CSR strobes.
module msrv_32_trap_controller
    import msrv_32_pkg::*;
(
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       trap_taken_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       misaligned_exception_out
);

    state_t     state, next_state;
    logic       system, ecall, ebreak, mret;
    logic       trap_present, is_interrupt, is_misaligned;
    logic [3:0] cause;

    always_comb begin
        system = opcode_6_to_2_in == OPCODE_SYSTEM && funct3_in == FUNCT3_PRIV &&
                 rs1_addr_in == 5'd0 && rd_addr_in == 5'd0;
        ecall  = system && funct7_in == FUNCT7_ENV  && rs2_addr_in == RS2_ECALL;
        ebreak = system && funct7_in == FUNCT7_ENV  && rs2_addr_in == RS2_EBREAK;
        mret   = system && funct7_in == FUNCT7_MRET && rs2_addr_in == RS2_MRET;
    end

    msrv_32_trap_priority u_priority (
        .illegal          (illegal_instr_in),
        .misaligned_instr (misaligned_instr_in),
        .ecall            (ecall),
        .ebreak           (ebreak),
        .misaligned_load  (misaligned_load_in),
        .misaligned_store (misaligned_store_in),
        .ext_int          (mie_in & meie_in & meip_in),
        .sw_int           (mie_in & msie_in & msip_in),
        .timer_int        (mie_in & mtie_in & mtip_in),
        .trap_present     (trap_present),
        .cause            (cause),
        .is_interrupt     (is_interrupt),
        .is_misaligned    (is_misaligned)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state                    <= ST_RESET;
            cause_out                <= 4'd0;
            i_or_e_out               <= 1'b0;
            misaligned_exception_out <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_OPERATING && trap_present) begin
                cause_out                <= cause;
                i_or_e_out               <= is_interrupt;
                misaligned_exception_out <= is_misaligned;
            end
        end
    end

    always_comb begin
        next_state      = ST_OPERATING;
        trap_taken_out  = 1'b0;
        pc_src_out      = PC_BOOT;
        flush_out       = 1'b1;
        set_cause_out   = 1'b0;
        set_epc_out     = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        case (state)
            ST_RESET: begin
            end
            ST_OPERATING: begin
                // a coincident interrupt is a trap, so it naturally wins over MRET
                next_state      = trap_present ? ST_TRAP_TAKEN : mret ? ST_TRAP_RETURN : ST_OPERATING;
                pc_src_out      = PC_NEXT;
                flush_out       = 1'b0;
                trap_taken_out  = trap_present;
                instret_inc_out = !trap_present;
            end
            ST_TRAP_TAKEN: begin
                pc_src_out    = PC_TRAP;
                set_cause_out = 1'b1;
                set_epc_out   = 1'b1;
                mie_clear_out = 1'b1;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                mie_set_out = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_msrv_32_trap_controller.sv
// tb_msrv_32_trap_controller: scoreboard bench; each step queues the expected output word and the sampled one.
module tb_msrv_32_trap_controller;

    typedef struct packed {
        logic       rst;
        logic       ill;
        logic       mld;
        logic       mst;
        logic       mis_i;
        logic [4:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mie;
        logic       meie;
        logic       mtie;
        logic       msie;
        logic       meip;
        logic       mtip;
        logic       msip;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ill = 1'b0, mld = 1'b0, mst = 1'b0, mis_i = 1'b0;
    logic [4:0] opc = 5'b01100;
    logic [2:0] f3 = 3'd0;
    logic [6:0] f7 = 7'd0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       mie = 1'b0, meie = 1'b0, mtie = 1'b0, msie = 1'b0;
    logic       meip = 1'b0, mtip = 1'b0, msip = 1'b0;

    logic       trap_taken, flush, set_cause, set_epc, mie_clear, mie_set, instret, i_or_e, mis_exc;
    logic [1:0] pc_src;
    logic [3:0] cause;
    logic [14:0] obs;

    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];
    string       name_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    msrv_32_trap_controller dut (
        .ms_riscv32_mp_clk_in     (clk),
        .ms_riscv32_mp_rst_in     (rst),
        .illegal_instr_in         (ill),
        .misaligned_load_in       (mld),
        .misaligned_store_in      (mst),
        .misaligned_instr_in      (mis_i),
        .opcode_6_to_2_in         (opc),
        .funct3_in                (f3),
        .funct7_in                (f7),
        .rs1_addr_in              (rs1),
        .rs2_addr_in              (rs2),
        .rd_addr_in               (rd),
        .mie_in                   (mie),
        .meie_in                  (meie),
        .mtie_in                  (mtie),
        .msie_in                  (msie),
        .meip_in                  (meip),
        .mtip_in                  (mtip),
        .msip_in                  (msip),
        .trap_taken_out           (trap_taken),
        .pc_src_out               (pc_src),
        .flush_out                (flush),
        .set_cause_out            (set_cause),
        .set_epc_out              (set_epc),
        .mie_clear_out            (mie_clear),
        .mie_set_out              (mie_set),
        .instret_inc_out          (instret),
        .cause_out                (cause),
        .i_or_e_out               (i_or_e),
        .misaligned_exception_out (mis_exc)
    );

    assign obs = {trap_taken, pc_src, flush, set_cause, set_epc, mie_clear, mie_set, instret, cause, i_or_e, mis_exc};

    function automatic logic [14:0] o_reset();
        return {1'b0, 2'b00, 1'b1, 5'b00000, 4'd0, 1'b0, 1'b0};
    endfunction

    function automatic logic [14:0] o_oper(input logic t, input logic [3:0] c, input logic ie, input logic m);
        return {t, 2'b10, 1'b0, 4'b0000, !t, c, ie, m};
    endfunction

    function automatic logic [14:0] o_taken(input logic [3:0] c, input logic ie, input logic m);
        return {1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, c, ie, m};
    endfunction

    function automatic logic [14:0] o_ret(input logic [3:0] c, input logic ie, input logic m);
        return {1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c, ie, m};
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        s.opc = 5'b01100;
        return s;
    endfunction

    function automatic stim_t sys(input logic [6:0] f7v, input logic [4:0] rs2v);
        stim_t s;
        s = nop();
        s.opc = 5'b11100;
        s.f7 = f7v;
        s.rs2 = rs2v;
        return s;
    endfunction

    // drives one cycle of stimulus after the edge and samples mid-cycle
    task automatic step(input string nm, input stim_t s, input logic [14:0] e);
        @(posedge clk);
        #1;
        {rst, ill, mld, mst, mis_i, opc, f3, f7, rs1, rs2, rd, mie, meie, mtie, msie, meip, mtip, msip} = s;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        obs_q.push_back(obs);
    endtask

    task automatic test_reset();
        stim_t s;
        logic [14:0] e, o;
        string nm;
        s = nop();
        s.rst = 1'b1;
        step("reset_hold", s, o_reset());
        step("reset_release", nop(), o_reset());
        step("first_operating", nop(), o_oper(1'b0, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset/%s: got %h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_exceptions();
        stim_t s;
        logic [14:0] e, o;
        string nm;
        s = nop(); s.ill = 1'b1; s.mst = 1'b1;
        step("illegal_with_store", s, o_oper(1'b1, 4'd0, 1'b0, 1'b0));
        step("illegal_taken", nop(), o_taken(4'd2, 1'b0, 1'b0));
        step("illegal_after", nop(), o_oper(1'b0, 4'd2, 1'b0, 1'b0));
        step("ecall", sys(7'd0, 5'd0), o_oper(1'b1, 4'd2, 1'b0, 1'b0));
        step("ecall_taken", nop(), o_taken(4'd11, 1'b0, 1'b0));
        step("ebreak", sys(7'd0, 5'd1), o_oper(1'b1, 4'd11, 1'b0, 1'b0));
        step("ebreak_taken", nop(), o_taken(4'd3, 1'b0, 1'b0));
        s = nop(); s.mld = 1'b1;
        step("load_b2b", s, o_oper(1'b1, 4'd3, 1'b0, 1'b0));
        step("load_taken", nop(), o_taken(4'd4, 1'b0, 1'b1));
        s = nop(); s.mis_i = 1'b1; s.mst = 1'b1;
        step("instr_over_store", s, o_oper(1'b1, 4'd4, 1'b0, 1'b1));
        step("instr_taken", nop(), o_taken(4'd0, 1'b0, 1'b1));
        s = nop(); s.mst = 1'b1;
        step("store", s, o_oper(1'b1, 4'd0, 1'b0, 1'b1));
        step("store_taken", nop(), o_taken(4'd6, 1'b0, 1'b1));
        s = sys(7'd0, 5'd0); s.rs1 = 5'd1;
        step("system_rs1_nonzero", s, o_oper(1'b0, 4'd6, 1'b0, 1'b1));
        s = sys(7'd0, 5'd0); s.f3 = 3'd1;
        step("system_funct3_nonzero", s, o_oper(1'b0, 4'd6, 1'b0, 1'b1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL exceptions/%s: got %h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_interrupts();
        stim_t s;
        logic [14:0] e, o;
        string nm;
        s = nop(); s.mie = 1'b1; s.mtie = 1'b1; s.mtip = 1'b1; s.msie = 1'b1; s.msip = 1'b1;
        step("sw_over_timer", s, o_oper(1'b1, 4'd6, 1'b0, 1'b1));
        step("sw_taken", s, o_taken(4'd3, 1'b1, 1'b0));
        s.mie = 1'b0;
        step("mie_off", s, o_oper(1'b0, 4'd3, 1'b1, 1'b0));
        s = nop(); s.mie = 1'b1; s.mtip = 1'b1; s.msip = 1'b1; s.meip = 1'b1;
        step("pending_not_enabled", s, o_oper(1'b0, 4'd3, 1'b1, 1'b0));
        s = nop(); s.mie = 1'b1; s.mtie = 1'b1; s.mtip = 1'b1;
        step("timer", s, o_oper(1'b1, 4'd3, 1'b1, 1'b0));
        step("timer_taken", nop(), o_taken(4'd7, 1'b1, 1'b0));
        s = nop(); s.mie = 1'b1; s.meie = 1'b1; s.meip = 1'b1; s.msie = 1'b1; s.msip = 1'b1;
        s.mtie = 1'b1; s.mtip = 1'b1;
        step("ext_over_all", s, o_oper(1'b1, 4'd7, 1'b1, 1'b0));
        step("ext_taken_ignored_input", s, o_taken(4'd11, 1'b1, 1'b0));
        s.mie = 1'b0;
        step("ext_still_pending_mie_off", s, o_oper(1'b0, 4'd11, 1'b1, 1'b0));
        s = nop(); s.ill = 1'b1; s.mie = 1'b1; s.meie = 1'b1; s.meip = 1'b1;
        step("exception_over_int", s, o_oper(1'b1, 4'd11, 1'b1, 1'b0));
        step("exception_taken", nop(), o_taken(4'd2, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL interrupts/%s: got %h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_mret();
        stim_t s;
        logic [14:0] e, o;
        string nm;
        step("mret", sys(7'b0011000, 5'd2), o_oper(1'b0, 4'd2, 1'b0, 1'b0));
        step("mret_return", nop(), o_ret(4'd2, 1'b0, 1'b0));
        step("mret_after", nop(), o_oper(1'b0, 4'd2, 1'b0, 1'b0));
        s = sys(7'b0011000, 5'd2); s.mie = 1'b1; s.meie = 1'b1; s.meip = 1'b1;
        step("mret_vs_ext", s, o_oper(1'b1, 4'd2, 1'b0, 1'b0));
        step("mret_vs_ext_taken", nop(), o_taken(4'd11, 1'b1, 1'b0));
        step("mret_wrong_rs2", sys(7'b0011000, 5'd3), o_oper(1'b0, 4'd11, 1'b1, 1'b0));
        step("mret_b2b", sys(7'b0011000, 5'd2), o_oper(1'b0, 4'd11, 1'b1, 1'b0));
        step("mret_b2b_return", sys(7'b0011000, 5'd2), o_ret(4'd11, 1'b1, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mret/%s: got %h want %h", nm, o, e);
            end
        end
    endtask

    task automatic test_reset_in_trap();
        stim_t s;
        logic [14:0] e, o;
        string nm;
        step("ecall", sys(7'd0, 5'd0), o_oper(1'b1, 4'd11, 1'b1, 1'b0));
        s = nop(); s.rst = 1'b1;
        step("taken_rst_asserted", s, o_taken(4'd11, 1'b0, 1'b0));
        step("reset_state", nop(), o_reset());
        step("operating_again", nop(), o_oper(1'b0, 4'd0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_in_trap/%s: got %h want %h", nm, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exceptions();
        test_interrupts();
        test_mret();
        test_reset_in_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
